// File: rtl/uart_link_ctrl_pkg.sv
// Shared types and sizing helpers for the UART link controller.
package uart_link_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } tx_state_e;

  localparam int FRAME_BITS_8P1 = 11;

  function automatic int frame_cycles(input int cpb, input int bits);
    return cpb * bits;
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_link_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request found
// after i_ptr, wrapping around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_gnt[w_idx]   = 1'b1;
        o_gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_link_ctrl.sv
// UART core sequencer: round-robin TX issue paced by frame time, gated RX capture
// into a valid/ready output with sticky overrun and saturating error counters.
//   state | meaning
//   IDLE  | req_ready live, waiting for a valid requester
//   ISSUE | one-cycle tx_en pulse, frame timer loaded
//   WAIT  | frame + guard time running, no new grants
module uart_link_ctrl
  import uart_link_ctrl_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  CLKS_PER_BIT = 16,
  parameter int  FRAME_BITS   = FRAME_BITS_8P1,
  parameter int  GUARD_CYCLES = 2,
  parameter int  CNT_W        = 8,
  parameter int  DROP_BAD     = 1,
  localparam int ID_W         = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 tx_busy,
  output logic                 tx_en,
  output logic [7:0]           data_in,
  input  logic                 rx_enable_cfg,
  output logic                 rx_en,
  input  logic [7:0]           data_out,
  input  logic                 data_ready,
  input  logic                 parity_error,
  input  logic                 stop_error,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic [CNT_W-1:0]     parity_err_cnt,
  output logic [CNT_W-1:0]     stop_err_cnt,
  input  logic                 clr_status
);

  localparam int TX_LOAD = frame_cycles(CLKS_PER_BIT, FRAME_BITS) + GUARD_CYCLES - 1;
  localparam int TXC_W   = $clog2(TX_LOAD + 1);

  tx_state_e          r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic [7:0]         r_data_in;
  logic               r_tx_en;
  logic               r_tx_busy;
  logic [TXC_W-1:0]   r_cnt;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [7:0]         w_sel_byte;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_sel_byte = req_data[8*i +: 8];
    end
  end

  // Gated by reset so the accept drops asynchronously along with everything else.
  assign req_ready = (r_state == IDLE && reset) ? w_gnt : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_data_in  <= '0;
      r_tx_en    <= 1'b0;
      r_tx_busy  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_data_in  <= w_sel_byte;
            r_ptr      <= w_gnt_idx;
            r_grant_id <= w_gnt_idx;
            r_tx_en    <= 1'b1;
            r_tx_busy  <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= TXC_W'(TX_LOAD);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_tx_busy <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_tx_busy <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign grant_id = r_grant_id;
  assign tx_busy  = r_tx_busy;
  assign tx_en    = r_tx_en;
  assign data_in  = r_data_in;

  logic             r_rx_en;
  logic             r_dr_d;
  logic             r_rx_valid;
  logic [7:0]       r_rx_data;
  logic             r_overrun;
  logic [CNT_W-1:0] r_par_cnt;
  logic [CNT_W-1:0] r_stop_cnt;

  logic w_rx_event;
  logic w_bad;
  logic w_deliver;

  assign w_rx_event = r_rx_en && data_ready && !r_dr_d;
  assign w_bad      = parity_error || stop_error;
  assign w_deliver  = w_rx_event && !((DROP_BAD != 0) && w_bad);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_en    <= 1'b0;
      r_dr_d     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_overrun  <= 1'b0;
      r_par_cnt  <= '0;
      r_stop_cnt <= '0;
    end else begin
      r_rx_en <= rx_enable_cfg;
      r_dr_d  <= data_ready;

      if (w_deliver && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= data_out;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      // A same-cycle clear beats any increment or overrun set.
      if (clr_status) begin
        r_overrun  <= 1'b0;
        r_par_cnt  <= '0;
        r_stop_cnt <= '0;
      end else begin
        if (w_deliver && r_rx_valid && !rx_ready) r_overrun <= 1'b1;
        if (w_rx_event && parity_error && !(&r_par_cnt)) r_par_cnt <= r_par_cnt + 1'b1;
        if (w_rx_event && stop_error && !(&r_stop_cnt)) r_stop_cnt <= r_stop_cnt + 1'b1;
      end
    end
  end

  assign rx_en          = r_rx_en;
  assign rx_valid       = r_rx_valid;
  assign rx_data        = r_rx_data;
  assign overrun        = r_overrun;
  assign parity_err_cnt = r_par_cnt;
  assign stop_err_cnt   = r_stop_cnt;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Scoreboard bench for uart_link_ctrl with CLKS_PER_BIT=4 (tx_en spacing 48 clks).
module tb_uart_link_ctrl;

  localparam int NR      = 4;
  localparam int SPACING = 4 * 11 + 2 + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic [1:0]    grant_id;
  logic          tx_busy, tx_en;
  logic [7:0]    data_in;
  logic          rx_enable_cfg = 1'b0;
  logic          rx_en;
  logic [7:0]    data_out = '0;
  logic          data_ready = 1'b0, parity_error = 1'b0, stop_error = 1'b0;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready = 1'b0;
  logic          overrun;
  logic [7:0]    parity_err_cnt, stop_err_cnt;
  logic          clr_status = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_byte_q[$];
  logic [1:0] exp_id_q[$];
  logic [7:0] rx_q[$];

  uart_link_ctrl #(
    .NUM_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(11), .GUARD_CYCLES(2), .CNT_W(8), .DROP_BAD(1)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .tx_busy(tx_busy), .tx_en(tx_en),
    .data_in(data_in), .rx_enable_cfg(rx_enable_cfg), .rx_en(rx_en), .data_out(data_out),
    .data_ready(data_ready), .parity_error(parity_error), .stop_error(stop_error),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .overrun(overrun),
    .parity_err_cnt(parity_err_cnt), .stop_err_cnt(stop_err_cnt), .clr_status(clr_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tx(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (tx_en) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!tx_busy) ok = 1'b1;
    end
  endtask

  task automatic rx_pulse(input logic [7:0] d, input logic pe, input logic se);
    @(negedge clk);
    data_out = d; parity_error = pe; stop_error = se; data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0; parity_error = 1'b0; stop_error = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 4'b1111;
    rx_enable_cfg = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    checks++; if ({tx_en, tx_busy, rx_en, rx_valid, overrun} !== 5'b0) begin failures++;
      $display("FAIL reset_flags got=%b want=00000", {tx_en, tx_busy, rx_en, rx_valid, overrun}); end
    checks++; if ({grant_id, data_in, rx_data, parity_err_cnt, stop_err_cnt} !== 34'h0) begin failures++;
      $display("FAIL reset_values got=%h want=0", {grant_id, data_in, rx_data, parity_err_cnt, stop_err_cnt}); end
    req_valid = '0;
    rx_enable_cfg = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit seen, ok;
    int last;
    logic [7:0] eb;
    logic [1:0] ei;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_byte_q.push_back(8'hA0 + 8'(i));
      exp_id_q.push_back(2'(i));
    end
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rr_first_ready got=%b want=0001", req_ready); end
    last = 0;
    for (int k = 0; k < 4; k++) begin
      wait_tx(60, seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL rr_tx_timeout pulse=%0d", k); end
      else begin
        eb = exp_byte_q.pop_front(); ei = exp_id_q.pop_front();
        checks++; if (data_in !== eb) begin failures++; $display("FAIL rr_data pulse=%0d got=%h want=%h", k, data_in, eb); end
        checks++; if (grant_id !== ei) begin failures++; $display("FAIL rr_grant pulse=%0d got=%0d want=%0d", k, grant_id, ei); end
        if (k > 0) begin
          checks++; if (cyc - last != SPACING) begin failures++; $display("FAIL rr_spacing got=%0d want=%0d", cyc - last, SPACING); end
        end
        last = cyc;
      end
      if (k == 3) req_valid = '0;
      if (k == 1) begin
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 4'b0000 || tx_busy !== 1'b1) begin failures++;
          $display("FAIL rr_wait_ready got ready=%b busy=%b want ready=0000 busy=1", req_ready, tx_busy); end
      end
    end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_drain_timeout busy=%b", tx_busy); end
  endtask

  task automatic test_rr_pointer();
    bit seen, ok;
    int last;
    logic [7:0] eb;
    logic [1:0] ei;
    req_data = {8'h00, 8'h5C, 8'h00, 8'h11};
    req_valid = 4'b0100;
    exp_byte_q.push_back(8'h5C); exp_id_q.push_back(2'd2);
    exp_byte_q.push_back(8'h11); exp_id_q.push_back(2'd0);
    exp_byte_q.push_back(8'h5C); exp_id_q.push_back(2'd2);
    last = 0;
    for (int k = 0; k < 3; k++) begin
      wait_tx(60, seen);
      checks++;
      if (!seen) begin failures++; $display("FAIL ptr_tx_timeout pulse=%0d", k); end
      else begin
        eb = exp_byte_q.pop_front(); ei = exp_id_q.pop_front();
        checks++; if (data_in !== eb) begin failures++; $display("FAIL ptr_data pulse=%0d got=%h want=%h", k, data_in, eb); end
        checks++; if (grant_id !== ei) begin failures++; $display("FAIL ptr_grant pulse=%0d got=%0d want=%0d", k, grant_id, ei); end
        if (k == 2) begin
          checks++; if (cyc - last != SPACING) begin failures++; $display("FAIL ptr_spacing got=%0d want=%0d", cyc - last, SPACING); end
        end
        last = cyc;
      end
      if (k == 0) req_valid = 4'b0101;
      if (k == 2) req_valid = '0;
    end
    // requester 1 raises and withdraws while the frame is still running
    repeat (5) @(negedge clk);
    req_valid = 4'b0010;
    repeat (5) @(negedge clk);
    req_valid = '0;
    wait_tx(80, seen);
    checks++; if (seen) begin failures++; $display("FAIL ptr_withdrawn_grant got tx_en with id=%0d want none", grant_id); end
    wait_idle(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ptr_drain_timeout busy=%b", tx_busy); end
  endtask

  task automatic test_reset_midframe();
    bit seen, ok;
    logic [7:0] eb;
    logic [1:0] ei;
    req_data = {8'h00, 8'h00, 8'h42, 8'h00};
    req_valid = 4'b0010;
    exp_byte_q.push_back(8'h42); exp_id_q.push_back(2'd1);
    wait_tx(10, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL mid_tx_timeout"); end
    else begin
      eb = exp_byte_q.pop_front(); ei = exp_id_q.pop_front();
      checks++; if (data_in !== eb || grant_id !== ei) begin failures++;
        $display("FAIL mid_first got=%h/%0d want=%h/%0d", data_in, grant_id, eb, ei); end
    end
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1111;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if ({tx_en, tx_busy, req_ready} !== 6'b0) begin failures++;
      $display("FAIL mid_async_drop got en=%b busy=%b ready=%b want all 0", tx_en, tx_busy, req_ready); end
    repeat (3) @(negedge clk);
    checks++; if (tx_en !== 1'b0 || grant_id !== 2'd0) begin failures++;
      $display("FAIL mid_held got en=%b id=%0d want en=0 id=0", tx_en, grant_id); end
    reset = 1'b1;
    exp_byte_q.push_back(8'hA0); exp_id_q.push_back(2'd0);
    wait_tx(10, seen);
    req_valid = '0;
    checks++;
    if (!seen) begin failures++; $display("FAIL mid_after_timeout"); end
    else begin
      eb = exp_byte_q.pop_front(); ei = exp_id_q.pop_front();
      checks++; if (data_in !== eb || grant_id !== ei) begin failures++;
        $display("FAIL mid_after_grant got=%h/%0d want=%h/%0d", data_in, grant_id, eb, ei); end
    end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_drain_timeout busy=%b", tx_busy); end
  endtask

  task automatic test_rx_overrun();
    rx_enable_cfg = 1'b1;
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rx_pulse(8'h3C, 1'b0, 1'b0);
    rx_q.push_back(8'h3C);
    checks++; if (rx_valid !== 1'b1 || rx_data !== rx_q[0] || overrun !== 1'b0) begin failures++;
      $display("FAIL ovr_first got v=%b d=%h o=%b want v=1 d=%h o=0", rx_valid, rx_data, overrun, rx_q[0]); end
    rx_pulse(8'h77, 1'b0, 1'b0);
    checks++; if (overrun !== 1'b1 || rx_data !== rx_q[0] || rx_valid !== 1'b1) begin failures++;
      $display("FAIL ovr_second got v=%b d=%h o=%b want v=1 d=%h o=1", rx_valid, rx_data, overrun, rx_q[0]); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(rx_q.pop_front());
    checks++; if (rx_valid !== 1'b0 || overrun !== 1'b1) begin failures++;
      $display("FAIL ovr_consume got v=%b o=%b want v=0 o=1", rx_valid, overrun); end
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b want=0", overrun); end
  endtask

  task automatic test_back_to_back_rx();
    rx_pulse(8'h10, 1'b0, 1'b0);
    rx_q.push_back(8'h10);
    checks++; if (rx_valid !== 1'b1 || rx_data !== rx_q[0]) begin failures++;
      $display("FAIL b2b_load got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, rx_q[0]); end
    @(negedge clk);
    data_out = 8'h20; data_ready = 1'b1; rx_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0; rx_ready = 1'b0;
    void'(rx_q.pop_front());
    rx_q.push_back(8'h20);
    checks++; if (rx_valid !== 1'b1 || rx_data !== rx_q[0] || overrun !== 1'b0) begin failures++;
      $display("FAIL b2b_reload got v=%b d=%h o=%b want v=1 d=%h o=0", rx_valid, rx_data, overrun, rx_q[0]); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(rx_q.pop_front());
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b want=0", rx_valid); end
  endtask

  task automatic test_err_saturate();
    bit ever_valid;
    ever_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rx_pulse(8'(i), 1'b1, 1'b0);
      if (rx_valid) ever_valid = 1'b1;
    end
    checks++; if (ever_valid) begin failures++; $display("FAIL sat_bad_delivered got rx_valid=1 want never"); end
    checks++; if (parity_err_cnt !== 8'hFF || stop_err_cnt !== 8'h00) begin failures++;
      $display("FAIL sat_counts got p=%h s=%h want p=ff s=00", parity_err_cnt, stop_err_cnt); end
    rx_pulse(8'hEE, 1'b1, 1'b1);
    checks++; if (parity_err_cnt !== 8'hFF || stop_err_cnt !== 8'h01 || rx_valid !== 1'b0) begin failures++;
      $display("FAIL sat_both got p=%h s=%h v=%b want p=ff s=01 v=0", parity_err_cnt, stop_err_cnt, rx_valid); end
    @(negedge clk);
    data_out = 8'h01; stop_error = 1'b1; data_ready = 1'b1; clr_status = 1'b1;
    @(negedge clk);
    data_ready = 1'b0; stop_error = 1'b0; clr_status = 1'b0;
    checks++; if (parity_err_cnt !== 8'h00 || stop_err_cnt !== 8'h00) begin failures++;
      $display("FAIL sat_clear_wins got p=%h s=%h want p=00 s=00", parity_err_cnt, stop_err_cnt); end
    rx_pulse(8'h02, 1'b0, 1'b1);
    checks++; if (parity_err_cnt !== 8'h00 || stop_err_cnt !== 8'h01) begin failures++;
      $display("FAIL sat_after_clear got p=%h s=%h want p=00 s=01", parity_err_cnt, stop_err_cnt); end
  endtask

  task automatic test_rx_disable();
    rx_pulse(8'h99, 1'b0, 1'b0);
    rx_q.push_back(8'h99);
    rx_enable_cfg = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rx_en !== 1'b0) begin failures++; $display("FAIL dis_rx_en got=%b want=0", rx_en); end
    rx_pulse(8'h55, 1'b1, 1'b0);
    checks++; if (rx_valid !== 1'b1 || rx_data !== rx_q[0] || overrun !== 1'b0 || parity_err_cnt !== 8'h00) begin failures++;
      $display("FAIL dis_retain got v=%b d=%h o=%b p=%h want v=1 d=%h o=0 p=00", rx_valid, rx_data, overrun, parity_err_cnt, rx_q[0]); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(rx_q.pop_front());
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL dis_consume got=%b want=0", rx_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rr_pointer();
    test_reset_midframe();
    test_rx_overrun();
    test_back_to_back_rx();
    test_err_saturate();
    test_rx_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
